// File: rtl/rvfi_serial_pkg.sv
// Shared types for the RVFI order serializer: the retirement record carried
// through the reorder window and out on the single in-order channel.
package rvfi_serial_pkg;

    localparam int ORDER_W   = 64;
    localparam int INSN_W    = 32;
    localparam int RVFI_XLEN = 32;

    typedef struct packed {
        logic [ORDER_W-1:0]   order;
        logic [INSN_W-1:0]    insn;
        logic                 trap;
        logic [RVFI_XLEN-1:0] pc_rdata;
        logic [RVFI_XLEN-1:0] pc_wdata;
    } rvfi_entry_t;

endpackage

// File: rtl/rvfi_reorder_window.sv
// DEPTH-entry reorder storage with per-slot valid bits, NRET prioritised write
// ports (lowest port wins a slot) and one read/clear port.
module rvfi_reorder_window
    import rvfi_serial_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                                    clock,
    input  logic                                    resetn,
    input  logic        [NRET-1:0]                  wr_en,
    input  logic        [NRET-1:0][$clog2(DEPTH)-1:0] wr_idx,
    input  rvfi_entry_t [NRET-1:0]                  wr_data,
    output logic        [NRET-1:0]                  wr_dup,
    input  logic        [$clog2(DEPTH)-1:0]         rd_idx,
    input  logic                                    rd_clear,
    output logic                                    rd_valid,
    output rvfi_entry_t                             rd_data,
    output logic        [$clog2(DEPTH):0]           count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic        [DEPTH-1:0] slot_valid;
    logic        [DEPTH-1:0] valid_nxt;
    rvfi_entry_t             slot_data [DEPTH];
    logic        [NRET-1:0]  wr_acc;
    logic                    hit;

    // A write is refused if the slot is already held or a lower port claims
    // the same slot this cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        wr_acc = '0;
        wr_dup = '0;
        hit    = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            hit = slot_valid[wr_idx[i]];
            for (int j = 0; j < i; j++) begin
                if (wr_en[j] && (wr_idx[j] == wr_idx[i])) hit = 1'b1;
            end
            if (wr_en[i]) begin
                if (hit) wr_dup[i] = 1'b1;
                else     wr_acc[i] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_nxt = slot_valid;
        if (rd_clear) valid_nxt[rd_idx] = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (wr_acc[i]) valid_nxt[wr_idx[i]] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) slot_valid <= '0;
        else         slot_valid <= valid_nxt;
    end

    // NOTE: the payload array is not reset; the valid bits alone decide whether a slot is meaningful.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NRET; i++) begin
            if (wr_acc[i]) slot_data[wr_idx[i]] <= wr_data[i];
        end
    end

    assign rd_valid = slot_valid[rd_idx];
    assign rd_data  = slot_data[rd_idx];

    always_comb begin
        count = '0;
        for (int d = 0; d < DEPTH; d++) begin
            count = count + {{IDX_W{1'b0}}, slot_valid[d]};
        end
    end

endmodule

// File: rtl/rvfi_order_serializer.sv
// Collects up to NRET RVFI retirements per cycle and replays them one per cycle
// in strictly ascending rvfi_order, flagging window overflow and duplicates.
module rvfi_order_serializer
    import rvfi_serial_pkg::*;
#(
    parameter int XLEN  = RVFI_XLEN,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NRET-1:0]           in_valid,
    input  logic [NRET*ORDER_W-1:0]   in_order,
    input  logic [NRET*INSN_W-1:0]    in_insn,
    input  logic [NRET-1:0]           in_trap,
    input  logic [NRET*XLEN-1:0]      in_pc_rdata,
    input  logic [NRET*XLEN-1:0]      in_pc_wdata,
    output logic                      out_valid,
    output logic [ORDER_W-1:0]        out_order,
    output logic [INSN_W-1:0]         out_insn,
    output logic                      out_trap,
    output logic [XLEN-1:0]           out_pc_rdata,
    output logic [XLEN-1:0]           out_pc_wdata,
    output logic                      err_window,
    output logic                      err_dup,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic        [ORDER_W-1:0]            exp_order;
    logic        [NRET-1:0][ORDER_W-1:0]  ch_order;
    logic        [NRET-1:0][ORDER_W-1:0]  ch_offset;
    logic        [NRET-1:0]               wr_en;
    logic        [NRET-1:0]               win_err;
    logic        [NRET-1:0]               wr_dup;
    logic        [NRET-1:0][IDX_W-1:0]    wr_idx;
    rvfi_entry_t [NRET-1:0]               wr_data;
    logic                                 rd_valid;
    rvfi_entry_t                          rd_data;
    rvfi_entry_t                          out_q;

    // Window test is done as (order >= exp) && (order - exp < DEPTH) so it
    // stays correct even when exp_order + DEPTH would overflow 64 bits.
    always_comb begin
        ch_order  = '0;
        ch_offset = '0;
        wr_en     = '0;
        win_err   = '0;
        wr_idx    = '0;
        wr_data   = '0;
        for (int i = 0; i < NRET; i++) begin
            ch_order[i]  = in_order[i*ORDER_W +: ORDER_W];
            ch_offset[i] = ch_order[i] - exp_order;
            wr_idx[i]    = ch_order[i][IDX_W-1:0];
            wr_data[i]   = '{order:    ch_order[i],
                             insn:     in_insn[i*INSN_W +: INSN_W],
                             trap:     in_trap[i],
                             pc_rdata: in_pc_rdata[i*XLEN +: XLEN],
                             pc_wdata: in_pc_wdata[i*XLEN +: XLEN]};
            if (in_valid[i]) begin
                if ((ch_order[i] >= exp_order) && (ch_offset[i] < ORDER_W'(DEPTH)))
                    wr_en[i] = 1'b1;
                else
                    win_err[i] = 1'b1;
            end
        end
    end

    rvfi_reorder_window #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_window (
        .clock    (clock),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_dup   (wr_dup),
        .rd_idx   (exp_order[IDX_W-1:0]),
        .rd_clear (rd_valid),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (occupancy)
    );

    // Emit the head slot when it is present; otherwise hold the last payload.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_order  <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            err_window <= 1'b0;
            err_dup    <= 1'b0;
        end else begin
            out_valid  <= rd_valid;
            if (rd_valid) begin
                out_q     <= rd_data;
                exp_order <= exp_order + 1'b1;
            end
            err_window <= err_window | (|win_err);
            err_dup    <= err_dup | (|wr_dup);
        end
    end

    assign out_order    = out_q.order;
    assign out_insn     = out_q.insn;
    assign out_trap     = out_q.trap;
    assign out_pc_rdata = out_q.pc_rdata;
    assign out_pc_wdata = out_q.pc_wdata;

endmodule
